// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: opcode and FSM state enums.
package calc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_OR  = 3'b010,
        OP_EQ  = 3'b011,
        OP_AND = 3'b100,
        OP_XOR = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/calc_seq_alu_if.sv
// Start/busy/done handshake bundle between the pin mapping and the calculator core.
interface calc_seq_alu_if #(parameter int WIDTH = 8);
    import calc_pkg::*;

    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             err;

    modport master (
        output start, op, a, b, acc_sel,
        input  busy, done, result, zero, carry, err
    );

    modport slave (
        input  start, op, a, b, acc_sel,
        output busy, done, result, zero, carry, err
    );

endinterface

// File: rtl/calc_muldiv.sv
// Iterative engine: right-shift shift-add multiply and restoring divide, one step per cycle.
// q_out/hi_nz present the value after the current step so the last step can be captured directly.
module calc_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] q_out,
    output logic             hi_nz
);

    logic [WIDTH-1:0] hi, lo, m;
    logic             div_mode;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    // Multiply keeps {hi,lo} as the product shifting right; divide keeps hi as remainder and lo as quotient.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        rem_sh  = {hi, lo[WIDTH-1]};
        ge      = rem_sh[WIDTH] || (rem_sh[WIDTH-1:0] >= m);
        rem_sub = rem_sh[WIDTH-1:0] - m;
        if (div_mode) begin
            hi_nx = ge ? rem_sub : rem_sh[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], ge};
        end else begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo[WIDTH-1:1]};
        end
        q_out = lo_nx;
        hi_nz = |hi_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            hi       <= '0;
            lo       <= is_div ? a : b;
            m        <= is_div ? b : a;
            div_mode <= is_div;
        end else if (step) begin
            hi <= hi_nx;
            lo <= lo_nx;
        end
    end

endmodule

// File: rtl/calc_seq_alu.sv
// Sequential calculator core: FSM, step counter, single-cycle ALU and output registers.
// Optional macro CALC_ACCUM_EN feeds the last result back as operand A when acc_sel is set.
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    calc_seq_alu_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             run_div;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, carry_q, err_q;
    logic             busy, done, load_eng, step_eng;

    op_t              op_in;
    logic [WIDTH-1:0] a_eff;
    logic             is_div_op, goes_run;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_err;
    logic [WIDTH-1:0] q_out;
    logic             hi_nz;

    assign op_in = op_t'(bus.op);
`ifdef CALC_ACCUM_EN
    assign a_eff = bus.acc_sel ? result_q : bus.a;
`else
    assign a_eff = bus.a;
`endif
    assign is_div_op = (op_in == OP_DIV);
    assign goes_run  = (op_in == OP_MUL) || (is_div_op && (bus.b != '0));
    assign cnt_nx    = cnt + CW'(1);

    // Single-cycle results; DIV only lands here when B is zero.
    always_comb begin
        sum       = {1'b0, a_eff} + {1'b0, bus.b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op_in)
            OP_ADD: begin alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; end
            OP_SUB: begin alu_res = a_eff - bus.b; alu_carry = (a_eff < bus.b); end
            OP_OR:  alu_res = a_eff | bus.b;
            OP_EQ:  alu_res = (a_eff == bus.b) ? '0 : WIDTH'(1);
            OP_AND: alu_res = a_eff & bus.b;
            OP_XOR: alu_res = a_eff ^ bus.b;
            OP_DIV: begin alu_res = '1; alu_err = 1'b1; end
            default: alu_res = '0;
        endcase
    end

    calc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_eng),
        .is_div (is_div_op),
        .a      (a_eff),
        .b      (bus.b),
        .step   (step_eng),
        .q_out  (q_out),
        .hi_nz  (hi_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = goes_run ? RUN : DONE;
            RUN:     if (cnt_nx == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        load_eng = (state == IDLE) && bus.start && goes_run;
        step_eng = (state == RUN);
    end

    // Output registers change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            run_div  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cnt     <= '0;
                    run_div <= is_div_op;
                    if (!goes_run) begin
                        result_q <= alu_res;
                        zero_q   <= (alu_res == '0);
                        carry_q  <= alu_carry;
                        err_q    <= alu_err;
                    end
                end
                RUN: begin
                    cnt <= cnt_nx;
                    if (cnt_nx == LAST) begin
                        result_q <= q_out;
                        zero_q   <= (q_out == '0);
                        carry_q  <= !run_div && hi_nz;
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Self-checking bench for calc_seq_alu (WIDTH=8): directed scenarios plus random ops against an arithmetic model.
module tb_calc_seq_alu;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [W-1:0] r_res;
    logic         r_zero, r_carry, r_err;

    calc_seq_alu_if #(.WIDTH(W)) bus ();

    calc_seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on integers.
    task automatic model(input int o, input int av, input int bv,
                         output int res, output int c, output int e, output int lat);
        int p;
        c = 0; e = 0; lat = 1;
        case (o)
            0: begin p = av + bv; res = p % 256; c = (p > 255) ? 1 : 0; end
            1: begin res = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0; end
            2: res = av | bv;
            3: res = (av == bv) ? 0 : 1;
            4: res = av & bv;
            5: res = av ^ bv;
            6: begin p = av * bv; res = p % 256; c = (p > 255) ? 1 : 0; lat = W + 1; end
            default: begin
                if (bv == 0) begin res = 255; e = 1; end
                else begin res = av / bv; lat = W + 1; end
            end
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic acc, output int lat, output int busy_n);
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv; bus.acc_sel = acc;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
        bus.acc_sel = 1'b0;
        lat = 1; busy_n = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy === 1'b1) busy_n++;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, lat);
        end
        r_res = bus.result; r_zero = bus.zero; r_carry = bus.carry; r_err = bus.err;
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b busy=%b after done, required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.acc_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.result, bus.zero, bus.carry, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b result=%0d zero=%b carry=%b err=%b, required all 0",
                     bus.busy, bus.done, bus.result, bus.zero, bus.carry, bus.err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        int lat, bn;
        run_op(3'b000, 8'd200, 8'd100, 1'b0, lat, bn);
        total++;
        if (lat !== 1 || r_res !== 8'd44 || r_carry !== 1'b1 || r_zero !== 1'b0 || r_err !== 1'b0) begin
            bad++;
            $display("FAIL add_overflow: lat=%0d res=%0d c=%b z=%b e=%b, required 1 44 1 0 0",
                     lat, r_res, r_carry, r_zero, r_err);
        end
    endtask

    task automatic test_sub_eq();
        int lat, bn;
        run_op(3'b001, 8'd5, 8'd9, 1'b0, lat, bn);
        total++;
        if (lat !== 1 || r_res !== 8'd252 || r_carry !== 1'b1 || r_zero !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow: lat=%0d res=%0d c=%b z=%b, required 1 252 1 0", lat, r_res, r_carry, r_zero);
        end
        run_op(3'b011, 8'd37, 8'd37, 1'b0, lat, bn);
        total++;
        if (r_res !== 8'd0 || r_zero !== 1'b1 || r_carry !== 1'b0) begin
            bad++;
            $display("FAIL eq_equal: res=%0d z=%b c=%b, required 0 1 0", r_res, r_zero, r_carry);
        end
    endtask

    task automatic test_mul();
        int lat, bn;
        run_op(3'b110, 8'd20, 8'd15, 1'b0, lat, bn);
        total++;
        if (lat !== 9 || bn !== 9 || r_res !== 8'd44 || r_carry !== 1'b1 || r_err !== 1'b0) begin
            bad++;
            $display("FAIL mul_latency: lat=%0d busy=%0d res=%0d c=%b e=%b, required 9 9 44 1 0",
                     lat, bn, r_res, r_carry, r_err);
        end
    endtask

    task automatic test_div();
        int lat, bn;
        run_op(3'b111, 8'd200, 8'd7, 1'b0, lat, bn);
        total++;
        if (lat !== 9 || r_res !== 8'd28 || r_carry !== 1'b0 || r_err !== 1'b0) begin
            bad++;
            $display("FAIL div: lat=%0d res=%0d c=%b e=%b, required 9 28 0 0", lat, r_res, r_carry, r_err);
        end
        run_op(3'b111, 8'd9, 8'd0, 1'b0, lat, bn);
        total++;
        if (lat !== 1 || r_res !== 8'd255 || r_err !== 1'b1 || r_carry !== 1'b0 || r_zero !== 1'b0) begin
            bad++;
            $display("FAIL div_zero: lat=%0d res=%0d e=%b c=%b z=%b, required 1 255 1 0 0",
                     lat, r_res, r_err, r_carry, r_zero);
        end
    endtask

    task automatic test_ignored_start();
        int lat, extra;
        bus.start = 1'b1; bus.op = 3'b110; bus.a = 8'd20; bus.b = 8'd15;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'd1; bus.b = 8'd1;
        @(posedge clk); #1; lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        total++;
        if (lat !== 9 || bus.result !== 8'd44) begin
            bad++;
            $display("FAIL ignored_start_mul: lat=%0d res=%0d, required 9 44", lat, bus.result);
        end
        extra = 0;
        repeat (12) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) extra++; end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ignored_start_queued: %0d active cycles after done, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bn, extra;
        run_op(3'b000, 8'd200, 8'd100, 1'b0, lat, bn);
        bus.start = 1'b1; bus.op = 3'b110; bus.a = 8'd20; bus.b = 8'd15;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.result, bus.zero, bus.carry, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%0d zero=%b carry=%b err=%b, required all 0",
                     bus.busy, bus.done, bus.result, bus.zero, bus.carry, bus.err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) extra++; end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL reset_discard: %0d active cycles after release, required 0", extra);
        end
    endtask

    task automatic test_accum();
        int lat, bn;
        logic [W-1:0] av;
        run_op(3'b000, 8'd10, 8'd5, 1'b0, lat, bn);
        total++;
        if (r_res !== 8'd15) begin
            bad++;
            $display("FAIL accum_first: res=%0d, required 15", r_res);
        end
        av = 8'd77;
        run_op(3'b000, av, 8'd5, 1'b1, lat, bn);
        total++;
`ifdef CALC_ACCUM_EN
        if (r_res !== 8'd20) begin
            bad++;
            $display("FAIL accum_chain: res=%0d, required 20", r_res);
        end
`else
        if (r_res !== av + 8'd5) begin
            bad++;
            $display("FAIL accum_ignored: res=%0d, required %0d", r_res, av + 8'd5);
        end
`endif
    endtask

    task automatic test_random();
        int lat, bn, er, ec, ee, el;
        logic [2:0]   o;
        logic [W-1:0] av, bv;
        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom_range(0, 7));
            av = W'($urandom);
            bv = (i % 6 == 0) ? '0 : W'($urandom);
            if (i % 9 == 0) bv = av;
            model(int'(o), int'(av), int'(bv), er, ec, ee, el);
            run_op(o, av, bv, 1'b0, lat, bn);
            total++;
            if (r_res !== W'(er) || r_zero !== (er == 0) || r_carry !== ec[0] || r_err !== ee[0]
                || lat !== el || bn !== el) begin
                bad++;
                $display("FAIL random op=%0d a=%0d b=%0d: res=%0d z=%b c=%b e=%b lat=%0d busy=%0d, required %0d %b %b %b %0d %0d",
                         o, av, bv, r_res, r_zero, r_carry, r_err, lat, bn,
                         er, (er == 0), ec[0], ee[0], el, el);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_eq();
        test_mul();
        test_div();
        test_ignored_start();
        test_reset_mid_run();
        test_accum();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
